axi4_lite_regfile: RTL and testbench
====================================

AXI4_LITE_REGFILE -- requirements
Module: axi4_lite_regfile

Interface
REQ-001 The block SHALL have one clock and one reset: reset is asynchronous and active-high.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, giving the data width (32 or 64).
REQ-003 The block SHALL have parameter ADDR_WIDTH, default 32, giving the address width.
REQ-004 The block SHALL have parameter NUM_REGS, default 8, giving the register count (1..256).
REQ-005 The block SHALL have parameter RO_MASK, NUM_REGS bits, default all 0, where bit i=1 marks register i as read-only status.
REQ-006 The block SHALL have the following ports, one per line as name, direction, width, meaning:
- aclk  in  1  clock
- areset  in  1  asynchronous active-high reset
- s_axi_awaddr/awvalid/awready  in/in/out  ADDR_WIDTH/1/1  write address channel
- s_axi_wdata/wstrb/wvalid/wready  in/in/in/out  DATA_WIDTH/DATA_WIDTH/8/1/1  write data channel
- s_axi_bresp/bvalid/bready  out/out/in  2/1/1  write response
- s_axi_araddr/arvalid/arready  in/in/out  ADDR_WIDTH/1/1  read address channel
- s_axi_rdata/rresp/rvalid/rready  out/out/out/in  DATA_WIDTH/2/1/1  read data channel
- ro_i  in  NUM_REGS*DATA_WIDTH  status values for read-only registers (register i at slice i)
- reg_o  out  NUM_REGS*DATA_WIDTH  current value of every writable register
- wr_pulse_o  out  NUM_REGS  one-cycle strobe per register on a committed write

Function
REQ-007 Register index SHALL be addr[LSB +: IDXW], with LSB=log2(DATA_WIDTH/8) and IDXW=max(1,ceil(log2(NUM_REGS))); address bits below LSB SHALL be ignored.
REQ-008 An address SHALL be out-of-range when addr >= NUM_REGS*(DATA_WIDTH/8).
REQ-009 The AW and W channels SHALL be accepted independently, in either order or in the same cycle, each into its own one-entry holding register.
REQ-010 awready SHALL be high only when the AW holding register is empty and bvalid is low; wready likewise for W.
REQ-011 When both holding registers are full and bvalid is low, the write SHALL commit in that cycle, set bvalid=1 on the next edge and empty both holding registers.
REQ-012 For an in-range writable register, each byte k of the register SHALL update only where wstrb[k]=1, wr_pulse_o[idx] SHALL be 1 for exactly one cycle, and bresp SHALL be 2'b00 (OKAY).
REQ-013 For an out-of-range address or an RO_MASK register, no state SHALL change, no wr_pulse_o bit SHALL assert, and bresp SHALL be 2'b10 (SLVERR).
REQ-014 bvalid/bresp SHALL hold until bready=1 is sampled; bvalid SHALL then clear on the next edge.
REQ-015 Back-to-back write throughput SHALL be one write per 2 cycles when bready is held high.
REQ-016 Write state machine: W_IDLE (no holding register full) -> W_PART (one full) -> W_RESP (bvalid=1) -> W_IDLE; W_IDLE -> W_RESP directly when AW and W handshake in the same cycle.
REQ-017 arready SHALL be high when rvalid is low.
REQ-018 On an AR handshake, rvalid SHALL be 1 on the next edge with registered rdata/rresp, giving read latency 1 cycle.
REQ-019 rdata SHALL be reg value (writable), ro_i slice sampled at the AR handshake (read-only), or 0 with rresp=2'b10 (out-of-range); rresp SHALL be 2'b00 otherwise.
REQ-020 rdata/rresp/rvalid SHALL be stable until rready=1 is sampled; rvalid SHALL then clear on the next edge.
REQ-021 The read and write paths SHALL operate concurrently.
REQ-022 A read handshake in the same cycle as a write commit to the same register SHALL return the pre-write value.
REQ-023 Holding AW with W never arriving SHALL NOT block reads.

Reset
REQ-024 While areset=1, asynchronously: all registers 0, holding registers empty, awready=wready=arready=0, bvalid=rvalid=0, bresp=rresp=2'b00, rdata=0, wr_pulse_o=0.
REQ-025 awready/wready/arready SHALL first assert on the first edge after areset deasserts.
REQ-026 Reset asserted mid-transaction SHALL abandon the transaction with no write committed and no response issued.

Verification
REQ-027 Write 0xDEADBEEF to 0x04 with AW 3 cycles before W -> bresp OKAY; read 0x04 -> 0xDEADBEEF, OKAY, latency 1; wr_pulse_o=8'b0000_0010 for one cycle.
REQ-028 With reg 2=0x11223344, write 0xAABBCCDD, wstrb 4'b0101 -> read 0x11BB33DD.
REQ-029 Write/read 0x20 (NUM_REGS=8) -> SLVERR both, rdata 0, no reg_o change.
REQ-030 RO_MASK=8'h80, ro_i slice 7=0x5A5A5A5A -> read 0x1C returns 0x5A5A5A5A OKAY; write 0x1C -> SLVERR, no pulse.
REQ-031 bready/rready held low 10 cycles -> bvalid/rvalid and payloads stable, awready=wready=0, arready=0 throughout.
REQ-032 areset pulse after AW accepted, before W -> all outputs at reset values, no reg_o change, subsequent write completes normally.

Source files
------------

// File: rtl/axi4_lite_regfile.sv
// AXI4-Lite slave register file.
//
// Purpose: NUM_REGS registers of DATA_WIDTH bits behind an AXI4-Lite slave port.
// Registers flagged in RO_MASK are read-only and return the live ro_i slice.
// Writable registers are exported on reg_o. A committed write pulses wr_pulse_o
// for one cycle.
//
// Ports:
//   aclk, areset          clock, asynchronous active-high reset
//   s_axi_aw*             write address channel (awaddr, awvalid, awready)
//   s_axi_w*              write data channel (wdata, wstrb, wvalid, wready)
//   s_axi_b*              write response channel (bresp, bvalid, bready)
//   s_axi_ar*             read address channel (araddr, arvalid, arready)
//   s_axi_r*              read data channel (rdata, rresp, rvalid, rready)
//   ro_i                  status inputs, register i at slice i
//   reg_o                 current register contents, register i at slice i
//   wr_pulse_o            one-cycle strobe per register on a committed write
module axi4_lite_regfile #(
  parameter int unsigned         DATA_WIDTH = 32,
  parameter int unsigned         ADDR_WIDTH = 32,
  parameter int unsigned         NUM_REGS   = 8,
  parameter logic [NUM_REGS-1:0] RO_MASK    = '0
) (
  input  logic                           aclk,
  input  logic                           areset,
  input  logic [ADDR_WIDTH-1:0]          s_axi_awaddr,
  input  logic                           s_axi_awvalid,
  output logic                           s_axi_awready,
  input  logic [DATA_WIDTH-1:0]          s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]        s_axi_wstrb,
  input  logic                           s_axi_wvalid,
  output logic                           s_axi_wready,
  output logic [1:0]                     s_axi_bresp,
  output logic                           s_axi_bvalid,
  input  logic                           s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]          s_axi_araddr,
  input  logic                           s_axi_arvalid,
  output logic                           s_axi_arready,
  output logic [DATA_WIDTH-1:0]          s_axi_rdata,
  output logic [1:0]                     s_axi_rresp,
  output logic                           s_axi_rvalid,
  input  logic                           s_axi_rready,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] ro_i,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_o,
  output logic [NUM_REGS-1:0]            wr_pulse_o
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned LSB    = $clog2(STRB_W);
  localparam int unsigned IDXW   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  // One extra bit so the byte limit never wraps for small address widths.
  localparam logic [ADDR_WIDTH:0] ADDR_LIMIT = (ADDR_WIDTH + 1)'(NUM_REGS * STRB_W);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {WIdle, WPart, WResp} w_state_e;

  w_state_e                      r_state, w_state_nxt;
  logic                          r_ready_en;
  logic                          r_aw_full;
  logic [ADDR_WIDTH-1:0]         r_aw_addr;
  logic                          r_w_full;
  logic [DATA_WIDTH-1:0]         r_w_data;
  logic [STRB_W-1:0]             r_w_strb;
  logic [1:0]                    r_bresp;
  logic [NUM_REGS*DATA_WIDTH-1:0] r_regs;
  logic [NUM_REGS-1:0]           r_wr_pulse;
  logic                          r_rvalid;
  logic [DATA_WIDTH-1:0]         r_rdata;
  logic [1:0]                    r_rresp;

  logic                  w_bvalid;
  logic                  w_aw_hs, w_w_hs, w_ar_hs;
  logic                  w_aw_have, w_w_have, w_commit;
  logic [ADDR_WIDTH-1:0] w_wr_addr;
  logic [DATA_WIDTH-1:0] w_wr_data;
  logic [STRB_W-1:0]     w_wr_strb;
  logic [IDXW-1:0]       w_wr_idx, w_rd_idx;
  logic                  w_wr_oor, w_wr_ok, w_rd_oor;

  // ---------------------------------------------------------------------------
  // Handshakes and write-commit decode
  // ---------------------------------------------------------------------------
  assign w_bvalid      = (r_state == WResp);
  // r_ready_en keeps all readies low until the first edge after reset release.
  assign s_axi_awready = r_ready_en & ~r_aw_full & ~w_bvalid;
  assign s_axi_wready  = r_ready_en & ~r_w_full & ~w_bvalid;
  assign s_axi_arready = r_ready_en & ~r_rvalid;

  assign w_aw_hs = s_axi_awvalid & s_axi_awready;
  assign w_w_hs  = s_axi_wvalid & s_axi_wready;
  assign w_ar_hs = s_axi_arvalid & s_axi_arready;

  // A channel arriving this cycle counts as held, so a write whose second half
  // lands now commits on the same edge (keeps back-to-back writes at 2 cycles).
  assign w_aw_have = r_aw_full | w_aw_hs;
  assign w_w_have  = r_w_full | w_w_hs;
  assign w_commit  = w_aw_have & w_w_have & ~w_bvalid;

  assign w_wr_addr = r_aw_full ? r_aw_addr : s_axi_awaddr;
  assign w_wr_data = r_w_full ? r_w_data : s_axi_wdata;
  assign w_wr_strb = r_w_full ? r_w_strb : s_axi_wstrb;

  assign w_wr_idx = w_wr_addr[LSB +: IDXW];
  assign w_wr_oor = ({1'b0, w_wr_addr} >= ADDR_LIMIT);
  assign w_wr_ok  = ~w_wr_oor & ~RO_MASK[w_wr_idx];

  assign w_rd_idx = s_axi_araddr[LSB +: IDXW];
  assign w_rd_oor = ({1'b0, s_axi_araddr} >= ADDR_LIMIT);

  // ---------------------------------------------------------------------------
  // Write FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      WIdle: begin
        if (w_commit) begin
          w_state_nxt = WResp;
        end else if (w_aw_hs || w_w_hs) begin
          w_state_nxt = WPart;
        end
      end
      WPart: begin
        if (w_commit) w_state_nxt = WResp;
      end
      WResp: begin
        if (s_axi_bready) w_state_nxt = WIdle;
      end
      default: w_state_nxt = WIdle;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state    <= WIdle;
      r_ready_en <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ready_en <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Holding registers, register array, write response
  // ---------------------------------------------------------------------------
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_aw_full  <= 1'b0;
      r_aw_addr  <= '0;
      r_w_full   <= 1'b0;
      r_w_data   <= '0;
      r_w_strb   <= '0;
      r_bresp    <= RESP_OKAY;
      r_regs     <= '0;
      r_wr_pulse <= '0;
    end else begin
      r_wr_pulse <= '0;
      if (w_commit) begin
        r_aw_full <= 1'b0;
        r_w_full  <= 1'b0;
        r_bresp   <= w_wr_ok ? RESP_OKAY : RESP_SLVERR;
        if (w_wr_ok) begin
          r_wr_pulse[w_wr_idx] <= 1'b1;
          for (int k = 0; k < STRB_W; k++) begin
            if (w_wr_strb[k]) begin
              r_regs[int'(w_wr_idx) * DATA_WIDTH + 8 * k +: 8] <= w_wr_data[8 * k +: 8];
            end
          end
        end
      end else begin
        if (w_aw_hs) begin
          r_aw_full <= 1'b1;
          r_aw_addr <= s_axi_awaddr;
        end
        if (w_w_hs) begin
          r_w_full <= 1'b1;
          r_w_data <= s_axi_wdata;
          r_w_strb <= s_axi_wstrb;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read path: one-cycle latency, payload captured at the AR handshake. A write
  // committing on the same edge is not yet visible in r_regs.
  // ---------------------------------------------------------------------------
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_rresp  <= RESP_OKAY;
    end else if (w_ar_hs) begin
      r_rvalid <= 1'b1;
      if (w_rd_oor) begin
        r_rdata <= '0;
        r_rresp <= RESP_SLVERR;
      end else if (RO_MASK[w_rd_idx]) begin
        r_rdata <= ro_i[int'(w_rd_idx) * DATA_WIDTH +: DATA_WIDTH];
        r_rresp <= RESP_OKAY;
      end else begin
        r_rdata <= r_regs[int'(w_rd_idx) * DATA_WIDTH +: DATA_WIDTH];
        r_rresp <= RESP_OKAY;
      end
    end else if (r_rvalid && s_axi_rready) begin
      r_rvalid <= 1'b0;
    end
  end

  assign s_axi_bvalid = w_bvalid;
  assign s_axi_bresp  = r_bresp;
  assign s_axi_rvalid = r_rvalid;
  assign s_axi_rdata  = r_rdata;
  assign s_axi_rresp  = r_rresp;
  // Read-only slots are never written, so they read back as zero here.
  assign reg_o        = r_regs;
  assign wr_pulse_o   = r_wr_pulse;

endmodule

// File: tb/tb_axi4_lite_regfile.sv
// Self-checking bench for axi4_lite_regfile (DATA_WIDTH=32, NUM_REGS=8,
// RO_MASK=8'h80). Table of directed write/read vectors plus hand-written
// sequences for split AW/W, stalls, same-cycle read/write, throughput, reset.
module tb_axi4_lite_regfile;

  logic         aclk, areset;
  logic [31:0]  awaddr, wdata, araddr, rdata;
  logic [3:0]   wstrb;
  logic         awvalid, awready, wvalid, wready, bvalid, bready;
  logic         arvalid, arready, rvalid, rready;
  logic [1:0]   bresp, rresp;
  logic [255:0] ro, regs;
  logic [7:0]   pulse;

  axi4_lite_regfile #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(32),
    .NUM_REGS  (8),
    .RO_MASK   (8'h80)
  ) dut (
    .aclk         (aclk),
    .areset       (areset),
    .s_axi_awaddr (awaddr),
    .s_axi_awvalid(awvalid),
    .s_axi_awready(awready),
    .s_axi_wdata  (wdata),
    .s_axi_wstrb  (wstrb),
    .s_axi_wvalid (wvalid),
    .s_axi_wready (wready),
    .s_axi_bresp  (bresp),
    .s_axi_bvalid (bvalid),
    .s_axi_bready (bready),
    .s_axi_araddr (araddr),
    .s_axi_arvalid(arvalid),
    .s_axi_arready(arready),
    .s_axi_rdata  (rdata),
    .s_axi_rresp  (rresp),
    .s_axi_rvalid (rvalid),
    .s_axi_rready (rready),
    .ro_i         (ro),
    .reg_o        (regs),
    .wr_pulse_o   (pulse)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int n_checks = 0;
  int n_errs   = 0;
  logic [31:0] m_reg [8];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_regs(input string name);
    logic [255:0] p;
    for (int i = 0; i < 8; i++) p[i*32 +: 32] = m_reg[i];
    check(name, regs, p);
  endtask

  // Called at a negedge; returns at a negedge with the response consumed.
  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [1:0] resp, output logic [7:0] pl);
    int  n;
    bit  aw_done, w_done;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    aw_done = 0; w_done = 0; n = 0;
    while (!(aw_done && w_done) && n < 20) begin
      if (awvalid && awready) aw_done = 1;
      if (wvalid && wready) w_done = 1;
      @(negedge aclk); n++;
      if (aw_done) awvalid = 1'b0;
      if (w_done) wvalid = 1'b0;
    end
    n = 0;
    while (!bvalid && n < 20) begin
      @(negedge aclk); n++;
    end
    check("write bvalid timeout", {255'b0, bvalid}, 256'd1);
    resp = bresp; pl = pulse;
    awvalid = 1'b0; wvalid = 1'b0;
    @(negedge aclk);
    bready = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
    int n;
    araddr = a; arvalid = 1'b1; rready = 1'b1; n = 0;
    while (!arready && n < 20) begin
      @(negedge aclk); n++;
    end
    @(negedge aclk);
    arvalid = 1'b0;
    check("read latency 1", {255'b0, rvalid}, 256'd1);
    d = rdata; resp = rresp;
    @(negedge aclk);
    rready = 1'b0;
  endtask

  typedef struct {
    bit          is_wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp_data;  // read data, or register value after an OKAY write
    logic [1:0]  exp_resp;
    logic [7:0]  exp_pulse;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];

  logic [1:0]  r_resp;
  logic [31:0] r_data;
  logic [7:0]  r_pl;

  initial begin
    vecs[0]  = '{1'b1, 32'h08, 32'h1122_3344, 4'hF, 32'h1122_3344, 2'b00, 8'h04};
    vecs[1]  = '{1'b1, 32'h08, 32'hAABB_CCDD, 4'h5, 32'h11BB_33DD, 2'b00, 8'h04};
    vecs[2]  = '{1'b0, 32'h08, 32'h0,         4'h0, 32'h11BB_33DD, 2'b00, 8'h00};
    vecs[3]  = '{1'b1, 32'h20, 32'hFFFF_FFFF, 4'hF, 32'h0,         2'b10, 8'h00};
    vecs[4]  = '{1'b0, 32'h20, 32'h0,         4'h0, 32'h0,         2'b10, 8'h00};
    vecs[5]  = '{1'b0, 32'h1C, 32'h0,         4'h0, 32'h5A5A_5A5A, 2'b00, 8'h00};
    vecs[6]  = '{1'b1, 32'h1C, 32'h1234_5678, 4'hF, 32'h0,         2'b10, 8'h00};
    vecs[7]  = '{1'b1, 32'h0E, 32'hCAFE_F00D, 4'hF, 32'hCAFE_F00D, 2'b00, 8'h08};
    vecs[8]  = '{1'b0, 32'h0C, 32'h0,         4'h0, 32'hCAFE_F00D, 2'b00, 8'h00};
    vecs[9]  = '{1'b1, 32'h00, 32'h0000_00AA, 4'h1, 32'h0000_00AA, 2'b00, 8'h01};
    vecs[10] = '{1'b0, 32'h00, 32'h0,         4'h0, 32'h0000_00AA, 2'b00, 8'h00};
    vecs[11] = '{1'b1, 32'h14, 32'h5566_7788, 4'h8, 32'h5500_0000, 2'b00, 8'h20};
    vecs[12] = '{1'b0, 32'h14, 32'h0,         4'h0, 32'h5500_0000, 2'b00, 8'h00};
    vecs[13] = '{1'b0, 32'h1F, 32'h0,         4'h0, 32'h5A5A_5A5A, 2'b00, 8'h00};

    for (int i = 0; i < 8; i++) begin
      m_reg[i] = 32'h0;
      ro[i*32 +: 32] = 32'hBAD0_0000 | i;
    end
    ro[7*32 +: 32] = 32'h5A5A_5A5A;

    areset = 1'b1;
    awaddr = '0; wdata = '0; wstrb = '0; araddr = '0;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;

    // Reset state
    repeat (2) @(negedge aclk);
    check("rst readies", {253'b0, awready, wready, arready}, 256'd0);
    check("rst valids", {254'b0, bvalid, rvalid}, 256'd0);
    check("rst resps", {252'b0, bresp, rresp}, 256'd0);
    check("rst rdata", {224'b0, rdata}, 256'd0);
    check("rst regs", regs, 256'd0);
    check("rst pulse", {248'b0, pulse}, 256'd0);
    areset = 1'b0;
    #1 check("ready before edge", {253'b0, awready, wready, arready}, 256'd0);
    @(negedge aclk);
    check("ready after edge", {253'b0, awready, wready, arready}, 256'd7);

    // AW first, W a few cycles later; a read is served meanwhile.
    awaddr = 32'h04; awvalid = 1'b1; bready = 1'b1;
    @(negedge aclk);
    awvalid = 1'b0;
    check("aw held awready", {255'b0, awready}, 256'd0);
    check("aw held wready", {255'b0, wready}, 256'd1);
    do_read(32'h08, r_data, r_resp);
    check("read during aw hold", {222'b0, r_resp, r_data}, 256'd0);
    wdata = 32'hDEAD_BEEF; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge aclk);
    wvalid = 1'b0;
    check("split bvalid", {255'b0, bvalid}, 256'd1);
    check("split bresp", {254'b0, bresp}, 256'd0);
    check("split pulse", {248'b0, pulse}, 256'h02);
    @(negedge aclk);
    check("split bvalid clear", {255'b0, bvalid}, 256'd0);
    check("split pulse clear", {248'b0, pulse}, 256'd0);
    bready = 1'b0;
    m_reg[1] = 32'hDEAD_BEEF;
    do_read(32'h04, r_data, r_resp);
    check("split readback", {222'b0, r_resp, r_data}, {222'b0, 2'b00, 32'hDEAD_BEEF});

    // Table-driven vectors
    for (int i = 0; i < NV; i++) begin
      if (vecs[i].is_wr) begin
        do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, r_resp, r_pl);
        check($sformatf("vec%0d bresp", i), {254'b0, r_resp}, {254'b0, vecs[i].exp_resp});
        check($sformatf("vec%0d pulse", i), {248'b0, r_pl}, {248'b0, vecs[i].exp_pulse});
        if (vecs[i].exp_resp == 2'b00) m_reg[vecs[i].addr[4:2]] = vecs[i].exp_data;
        check_regs($sformatf("vec%0d reg_o", i));
      end else begin
        do_read(vecs[i].addr, r_data, r_resp);
        check($sformatf("vec%0d rdata", i), {224'b0, r_data}, {224'b0, vecs[i].exp_data});
        check($sformatf("vec%0d rresp", i), {254'b0, r_resp}, {254'b0, vecs[i].exp_resp});
      end
    end

    // Back-pressure on both response channels for 10 cycles
    awaddr = 32'h10; wdata = 32'h0F0F_0F0F; wstrb = 4'hF; araddr = 32'h04;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1; bready = 1'b0; rready = 1'b0;
    @(negedge aclk);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      check($sformatf("stall%0d b", c), {253'b0, bvalid, bresp}, {253'b0, 1'b1, 2'b00});
      check($sformatf("stall%0d r", c), {221'b0, rvalid, rresp, rdata},
            {221'b0, 1'b1, 2'b00, 32'hDEAD_BEEF});
      check($sformatf("stall%0d readies", c), {253'b0, awready, wready, arready}, 256'd0);
      @(negedge aclk);
    end
    bready = 1'b1; rready = 1'b1;
    @(negedge aclk);
    check("stall release", {254'b0, bvalid, rvalid}, 256'd0);
    bready = 1'b0; rready = 1'b0;
    m_reg[4] = 32'h0F0F_0F0F;
    check_regs("stall reg_o");

    // Read and write commit to the same register on the same edge
    awaddr = 32'h10; wdata = 32'h1212_1212; wstrb = 4'hF; araddr = 32'h10;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1; bready = 1'b1; rready = 1'b1;
    @(negedge aclk);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    check("rw same cycle rdata", {223'b0, rvalid, rdata}, {223'b0, 1'b1, 32'h0F0F_0F0F});
    m_reg[4] = 32'h1212_1212;
    check_regs("rw same cycle reg_o");
    @(negedge aclk);
    bready = 1'b0; rready = 1'b0;

    // Back-to-back writes with bready high: one every 2 cycles
    awaddr = 32'h00; wdata = 32'h0101_0101; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    @(negedge aclk);
    check("b2b first", {247'b0, bvalid, pulse}, {247'b0, 1'b1, 8'h01});
    awaddr = 32'h04; wdata = 32'h0202_0202;
    @(negedge aclk);
    check("b2b gap", {254'b0, bvalid, awready}, {254'b0, 1'b0, 1'b1});
    @(negedge aclk);
    check("b2b second", {247'b0, bvalid, pulse}, {247'b0, 1'b1, 8'h02});
    awvalid = 1'b0; wvalid = 1'b0;
    @(negedge aclk);
    bready = 1'b0;
    m_reg[0] = 32'h0101_0101; m_reg[1] = 32'h0202_0202;
    check_regs("b2b reg_o");

    // Reset after AW accepted, before W
    awaddr = 32'h18; awvalid = 1'b1; bready = 1'b1;
    @(negedge aclk);
    awvalid = 1'b0;
    #2 areset = 1'b1;
    #1;
    check("midrst readies", {253'b0, awready, wready, arready}, 256'd0);
    check("midrst valids", {252'b0, bvalid, rvalid, pulse != 8'h0, rdata != 32'h0}, 256'd0);
    for (int i = 0; i < 8; i++) m_reg[i] = 32'h0;
    check_regs("midrst reg_o");
    @(negedge aclk);
    areset = 1'b0;
    @(negedge aclk);
    check("midrst no response", {255'b0, bvalid}, 256'd0);
    check("midrst readies back", {253'b0, awready, wready, arready}, 256'd7);
    do_write(32'h18, 32'h600D_F00D, 4'hF, r_resp, r_pl);
    check("post-rst write", {246'b0, r_resp, r_pl}, {246'b0, 2'b00, 8'h40});
    m_reg[6] = 32'h600D_F00D;
    check_regs("post-rst reg_o");
    do_read(32'h18, r_data, r_resp);
    check("post-rst read", {222'b0, r_resp, r_data}, {222'b0, 2'b00, 32'h600D_F00D});

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
